// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared types and constants for the "011" detector test sequencer.
//   state_t       : controller FSM states (binary encoded)
//   DRAIN_CYCLES  : cycles spent after the last serial bit so the detector's
//                   Moore output for that bit can still be sampled
//   calc_len_w()  : width needed to hold a bit count from 0 up to WIDTH
// ---------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DRAIN_CYCLES = 2;

  // A length field must represent every value 0..width inclusive.
  function automatic int calc_len_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_det_shifter.sv
// ---------------------------------------------------------------------------
// seq_det_shifter
// Load/shift register plus remaining-bit counter for the test sequencer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture data and the clamped length (start of a run)
//   shift_en   : present the next MSB on ser_out and advance
//   data, len  : word to send (MSB first) and requested bit count
//   ser_out    : registered serial bit, 0 whenever not shifting
//   last_bit   : exactly one bit remains to be sent
//   empty      : no bits remain
// ---------------------------------------------------------------------------
module seq_det_shifter
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = calc_len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             ser_out,
  output logic             last_bit,
  output logic             empty
);

  logic [WIDTH-1:0] shift_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_clamped;

  // Requests longer than the register can hold are cut down to a full word.
  assign len_clamped = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

  assign last_bit = (cnt_q == LEN_W'(1));
  assign empty    = (cnt_q == '0);

  // Load wins over shifting. The serial output drops back to 0 on any cycle
  // that does not shift, so the detector sees a quiet line between runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      ser_out <= 1'b0;
    end else if (load) begin
      shift_q <= data;
      cnt_q   <= len_clamped;
      ser_out <= 1'b0;
    end else if (shift_en) begin
      ser_out <= shift_q[WIDTH-1];
      shift_q <= {shift_q[WIDTH-2:0], 1'b0};
      cnt_q   <= cnt_q - LEN_W'(1);
    end else begin
      ser_out <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// seq_det_ctrl
// Test sequencer for a serial "011" Moore detector. On Start it clears the
// detector, streams a latched word MSB-first onto the detector input, counts
// detection pulses and reports the count with a one-cycle Done pulse.
// Ports:
//   Clk, Rst   : clock, asynchronous active-high reset
//   Start      : run request (only looked at in IDLE)
//   Data, Len  : word to send and number of bits (clamped to WIDTH)
//   Busy       : run in progress
//   Done       : one-cycle end-of-run pulse
//   Match_Cnt  : detections seen in the last run
//   Det_Rst    : registered clear to the detector
//   Det_X      : registered serial bit to the detector
//   Det_Y      : detector Moore output
//   First_Pos  : (only with SEQ_DET_CTRL_FIRST_POS_EN) 1-based index of the
//                bit completing the first detection, 0 if none
// Optional feature macro: SEQ_DET_CTRL_FIRST_POS_EN
// ---------------------------------------------------------------------------
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int LEN_W = calc_len_w(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data,
  input  logic [LEN_W-1:0] Len,
  output logic             Busy,
  output logic             Done,
  output logic [LEN_W-1:0] Match_Cnt,
  output logic             Det_Rst,
  output logic             Det_X,
  input  logic             Det_Y
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
  ,
  output logic [LEN_W-1:0] First_Pos
`endif
);

  state_t     state_q, state_d;
  logic       start_accept;
  logic       shift_en;
  logic       last_bit;
  logic       cnt_empty;
  logic [1:0] drain_q;
  logic       load_d1, load_d2;

  seq_det_shifter #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shifter (
    .clk      (Clk),
    .rst      (Rst),
    .load     (start_accept),
    .shift_en (shift_en),
    .data     (Data),
    .len      (Len),
    .ser_out  (Det_X),
    .last_bit (last_bit),
    .empty    (cnt_empty)
  );

  // State register; reset aborts any run straight back to IDLE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control decode. The first bit is shifted out on the edge
  // that leaves CLR, so the detector (cleared during CLR) sees bit 1 right
  // after its reset. A zero-length run still spends its one CLR cycle, which
  // puts Done one cycle after acceptance, but no bits and no detector clear.
  always_comb begin
    state_d      = state_q;
    Busy         = 1'b0;
    Done         = 1'b0;
    start_accept = 1'b0;
    shift_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          start_accept = 1'b1;
          state_d      = CLR;
        end
      end
      CLR: begin
        Busy = 1'b1;
        if (cnt_empty) begin
          state_d = DONE;
        end else begin
          shift_en = 1'b1;
          state_d  = last_bit ? DRAIN : SHIFT;
        end
      end
      SHIFT: begin
        Busy     = 1'b1;
        shift_en = !cnt_empty;
        if (last_bit || cnt_empty) state_d = DRAIN;
      end
      DRAIN: begin
        Busy = 1'b1;
        if (drain_q == 2'(DRAIN_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts cycles spent in DRAIN so the last bit's response gets through.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                  drain_q <= '0;
    else if (state_q == DRAIN) drain_q <= drain_q + 2'd1;
    else                      drain_q <= '0;
  end

  // The detector clear is registered so it is high for exactly the CLR cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) Det_Rst <= 1'b0;
    else     Det_Rst <= start_accept && (Len != '0);
  end

  // A bit loaded at edge k shows up on Y (Moore, one register inside the
  // detector) in time to be sampled at edge k+2. Delaying the shift strobe by
  // two edges gives exactly one sample per bit sent and ignores Y otherwise.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      load_d1 <= 1'b0;
      load_d2 <= 1'b0;
    end else begin
      load_d1 <= shift_en;
      load_d2 <= load_d1;
    end
  end

  // Detection counter: cleared on a new run, holds after Done.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                  Match_Cnt <= '0;
    else if (start_accept)    Match_Cnt <= '0;
    else if (load_d2 && Det_Y) Match_Cnt <= Match_Cnt + LEN_W'(1);
  end

`ifdef SEQ_DET_CTRL_FIRST_POS_EN
  logic [LEN_W-1:0] sample_idx;

  // sample_idx counts window samples taken so far, so sample_idx+1 is the
  // index of the bit whose response is being sampled now. Only the first
  // detection of a run is recorded.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sample_idx <= '0;
      First_Pos  <= '0;
    end else if (start_accept) begin
      sample_idx <= '0;
      First_Pos  <= '0;
    end else if (load_d2) begin
      sample_idx <= sample_idx + LEN_W'(1);
      if (Det_Y && (First_Pos == '0)) First_Pos <= sample_idx + LEN_W'(1);
    end
  end
`else
  // This build reports only the detection count.
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_det_ctrl
// Bench for seq_det_ctrl: a behavioural "011" Moore detector sits on the
// Det_* ports, directed and random runs are applied, and all results are
// compared against counts computed directly from the bit strings.
// ---------------------------------------------------------------------------
module tb_seq_det_ctrl;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [15:0] Data;
  logic [4:0]  Len;
  logic        Busy;
  logic        Done;
  logic [4:0]  Match_Cnt;
  logic        Det_Rst;
  logic        Det_X;
  logic        Det_Y;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
  logic [4:0]  First_Pos;
`endif

  int   total;
  int   bad;
  logic noise_y;
  logic [1:0] seen;

  seq_det_ctrl dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Data      (Data),
    .Len       (Len),
    .Busy      (Busy),
    .Done      (Done),
    .Match_Cnt (Match_Cnt),
    .Det_Rst   (Det_Rst),
    .Det_X     (Det_X),
    .Det_Y     (Det_Y)
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
    ,
    .First_Pos (First_Pos)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Detector stand-in: 'seen' is how much of "011" the recent input matches.
  // Y is high while the full pattern has just been seen; noise_y lets the
  // bench wiggle Y at times the controller must ignore.
  always @(posedge Clk or posedge Rst) begin
    if (Rst || Det_Rst) seen <= 2'd0;
    else if (!Det_X)    seen <= 2'd1;
    else if (seen == 2'd1) seen <= 2'd2;
    else if (seen == 2'd2) seen <= 2'd3;
    else                seen <= 2'd0;
  end
  assign Det_Y = (seen == 2'd3) | noise_y;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Count "011" occurrences in bits 1..lc (bit k = d[16-k]) and note where
  // the first one ends.
  function automatic void refModel(input logic [15:0] d, input int lc, output int cnt, output int fpos);
    cnt  = 0;
    fpos = 0;
    for (int k = 3; k <= lc; k++) begin
      if (d[18-k] == 1'b0 && d[17-k] == 1'b1 && d[16-k] == 1'b1) begin
        cnt++;
        if (fpos == 0) fpos = k;
      end
    end
  endfunction

  // One run. abort_k > 0 pulses Rst just after edge E(abort_k); repulse
  // raises Start with junk Data/Len so it is sampled at E4.
  task automatic applyStimulus(input logic [15:0] d, input logic [4:0] ln, input int abort_k, input bit repulse);
    int lc, exp_cnt, exp_first, done_edge;
    lc = (ln > 5'd16) ? 16 : int'(ln);
    refModel(d, lc, exp_cnt, exp_first);
    done_edge = (lc == 0) ? 1 : lc + 2;

    repeat (2) begin
      @(negedge Clk);
      noise_y = 1'($urandom);
    end
    Data  = d;
    Len   = ln;
    Start = 1'b1;
    @(negedge Clk);
    Start   = 1'b0;
    noise_y = 1'b0;
    Data    = 16'($urandom);
    Len     = 5'($urandom);
    checkOutput("done_after_e0", Done, 1'b0);
    if (lc != 0) begin
      checkOutput("det_rst_clr", Det_Rst, 1'b1);
      checkOutput("busy_after_e0", Busy, 1'b1);
    end

    for (int k = 1; k <= done_edge + 1; k++) begin
      if (repulse && k == 4 && done_edge > 4) begin
        Start = 1'b1;
        Data  = 16'($urandom);
        Len   = 5'($urandom);
      end
      @(negedge Clk);
      Start = 1'b0;

      if (k == abort_k) begin
        #2 Rst = 1'b1;
        #1;
        checkOutput("abort_outputs", {Busy, Done, Det_Rst, Det_X, Match_Cnt}, '0);
        #1 Rst = 1'b0;
        repeat (done_edge + 2) begin
          @(negedge Clk);
          checkOutput("abort_no_done", Done, 1'b0);
        end
        return;
      end

      if (k <= lc) checkOutput($sformatf("det_x_bit%0d", k), Det_X, d[16-k]);
      if (k == 1 && lc != 0) checkOutput("det_rst_single", Det_Rst, 1'b0);
      if (k < done_edge) begin
        checkOutput("done_early", Done, 1'b0);
        if (lc != 0) checkOutput("busy_run", Busy, 1'b1);
      end
      if (k == done_edge) begin
        checkOutput("done_pulse", Done, 1'b1);
        checkOutput("busy_at_done", Busy, 1'b0);
        checkOutput("match_cnt", Match_Cnt, exp_cnt);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        checkOutput("first_pos", First_Pos, exp_first);
`endif
      end
      if (k == done_edge + 1) begin
        checkOutput("done_single", Done, 1'b0);
        checkOutput("match_hold", Match_Cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total   = 0;
    bad     = 0;
    Rst     = 1'b1;
    Start   = 1'b0;
    Data    = '0;
    Len     = '0;
    noise_y = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("reset_busy", Busy, 1'b0);
    checkOutput("reset_done", Done, 1'b0);
    checkOutput("reset_match", Match_Cnt, '0);
    checkOutput("reset_det_rst", Det_Rst, 1'b0);
    checkOutput("reset_det_x", Det_X, 1'b0);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
    checkOutput("reset_first_pos", First_Pos, '0);
`endif
    Rst = 1'b0;

    applyStimulus(16'h6000, 5'd3, 0, 1'b0);
    applyStimulus(16'h6DB6, 5'd16, 0, 1'b0);
    applyStimulus(16'hFFFF, 5'd0, 0, 1'b0);
    applyStimulus(16'hFFFF, 5'd20, 0, 1'b0);
    applyStimulus(16'h6000, 5'd3, 0, 1'b1);
    applyStimulus(16'h6000, 5'd3, 0, 1'b0);
    applyStimulus(16'h6DB6, 5'd16, 8, 1'b0);
    applyStimulus(16'h6DB6, 5'd16, 0, 1'b0);
    applyStimulus(16'h0000, 5'd16, 0, 1'b0);
    applyStimulus(16'h4000, 5'd1, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'($urandom), 5'($urandom_range(0, 20)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 12)) : 0,
                    1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
